// File: rtl/demux_pkg.sv
// Shared types for the stream demultiplexer: the packet FSM state encoding.
package demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

endpackage

// File: rtl/stream_demux_1ton_onehot_dec.sv
// Binary-to-one-hot decoder; any select value >= N produces an all-zero vector.
module onehot_dec #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [SEL_W-1:0] sel_i,
    output logic [N-1:0]     onehot_o
);

    // NOTE: every bit gets a default before the loop, so no latch can be inferred.
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_i == SEL_W'(i)) onehot_o[i] = 1'b1;
        end
    end

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1:N stream demux: channel locked on the first beat of each packet,
// one-entry output register, out-of-range packets discarded and counted.
module stream_demux_1ton
    import demux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(N_CH),
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [SEL_W-1:0]  s_sel,
    input  logic              s_last,
    output logic [N_CH-1:0]   m_valid,
    input  logic [N_CH-1:0]   m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              busy
);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    ch_q, ch_d;
    logic                ov_q, ov_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    drop_q, drop_d;

    logic [N_CH-1:0]     ch_onehot;
    logic                sel_ok;
    logic                out_done;
    logic                accept;
    logic                load;
    logic                drop_inc;

    onehot_dec #(.N(N_CH), .SEL_W(SEL_W)) u_dec (
        .sel_i    (ch_q),
        .onehot_o (ch_onehot)
    );

    // Constant-true when N_CH is a power of two; the drop path then folds away.
    assign sel_ok   = ({1'b0, s_sel} < (SEL_W+1)'(N_CH));
    assign m_valid  = ov_q ? ch_onehot : '0;
    assign out_done = |(m_valid & m_ready);

    // Ready depends on m_ready and state only, never on s_valid.
    always_comb begin
        if (rst)                     s_ready = 1'b0;
        else if (state_q == ST_DROP) s_ready = 1'b1;
        else                         s_ready = !ov_q || out_done;
    end

    assign accept = s_valid && s_ready;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        load     = 1'b0;
        drop_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (sel_ok) begin
                        load    = 1'b1;
                        ch_d    = s_sel;
                        state_d = s_last ? ST_IDLE : ST_ROUTE;
                    end else begin
                        drop_inc = 1'b1;
                        state_d  = s_last ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_ROUTE: begin
                if (accept) begin
                    load = 1'b1;
                    if (s_last) state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (accept && s_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A load and a completion in the same cycle keeps ov set: back-to-back refill.
    always_comb begin
        ov_d   = ov_q;
        data_d = data_q;
        last_d = last_q;
        if (load) begin
            ov_d   = 1'b1;
            data_d = s_data;
            last_d = s_last;
        end else if (out_done) begin
            ov_d = 1'b0;
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (drop_inc && (drop_q != {CNT_W{1'b1}})) drop_d = drop_q + 1'b1;
    end

    // NOTE: all state uses non-blocking assignment so every register samples
    // pre-edge values. The payload register is reset too, because m_data=0
    // after reset is an observable requirement.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            ov_q    <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            ov_q    <= ov_d;
            data_q  <= data_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
        end
    end

    assign m_data   = data_q;
    assign m_last   = last_q;
    assign drop_cnt = drop_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Directed bench: a 4-channel instance for routing, lock, backpressure and
// mid-packet reset, and a 5-channel instance for out-of-range drop handling.
module tb_stream_demux_1ton;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4-channel instance
    logic       s_valid4, s_ready4, s_last4, m_last4, busy4;
    logic [7:0] s_data4, m_data4, drop4;
    logic [1:0] s_sel4;
    logic [3:0] m_valid4, m_ready4;

    // 5-channel instance
    logic       s_valid5, s_ready5, s_last5, m_last5, busy5;
    logic [7:0] s_data5, m_data5, drop5;
    logic [2:0] s_sel5;
    logic [4:0] m_valid5, m_ready5;

    int tests_run = 0;
    int tests_failed = 0;

    stream_demux_1ton #(.N_CH(4), .DATA_W(8), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4),
        .s_sel(s_sel4), .s_last(s_last4),
        .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4),
        .m_last(m_last4), .drop_cnt(drop4), .busy(busy4)
    );

    stream_demux_1ton #(.N_CH(5), .DATA_W(8), .CNT_W(8)) u_dut5 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid5), .s_ready(s_ready5), .s_data(s_data5),
        .s_sel(s_sel5), .s_last(s_last5),
        .m_valid(m_valid5), .m_ready(m_ready5), .m_data(m_data5),
        .m_last(m_last5), .drop_cnt(drop5), .busy(busy5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat4(input logic [1:0] sel, input logic [7:0] data, input logic last);
        s_valid4 = 1'b1;
        s_sel4   = sel;
        s_data4  = data;
        s_last4  = last;
    endtask

    task automatic beat5(input logic [2:0] sel, input logic [7:0] data, input logic last);
        s_valid5 = 1'b1;
        s_sel5   = sel;
        s_data5  = data;
        s_last5  = last;
    endtask

    initial begin
        rst = 1'b1;
        s_valid4 = 1'b1; s_sel4 = '0; s_data4 = '0; s_last4 = 1'b0; m_ready4 = 4'b1111;
        s_valid5 = 1'b1; s_sel5 = '0; s_data5 = '0; s_last5 = 1'b0; m_ready5 = 5'b11111;

        // Reset held 2 clocks with s_valid asserted
        #1;
        check("rst_s_ready", 32'(s_ready4), 32'h0);
        tick();
        tick();
        check("rst_s_ready_2", 32'(s_ready4), 32'h0);
        check("rst_m_valid", 32'(m_valid4), 32'h0);
        check("rst_m_data", 32'(m_data4), 32'h0);
        check("rst_m_last", 32'(m_last4), 32'h0);
        check("rst_drop", 32'(drop4), 32'h0);
        check("rst_busy", 32'(busy4), 32'h0);
        check("rst_drop5", 32'(drop5), 32'h0);
        check("rst_s_ready5", 32'(s_ready5), 32'h0);
        rst = 1'b0;
        s_valid4 = 1'b0;
        s_valid5 = 1'b0;
        tick();
        check("idle_m_valid", 32'(m_valid4), 32'h0);

        // Single-beat packets to every channel, back to back
        for (int i = 0; i < 4; i++) begin
            beat4(2'(i), 8'hA0 + 8'(i), 1'b1);
            #1;
            check("single_s_ready", 32'(s_ready4), 32'h1);
            tick();
            check("single_m_valid", 32'(m_valid4), 32'h1 << i);
            check("single_m_data", 32'(m_data4), 32'hA0 + 32'(i));
            check("single_m_last", 32'(m_last4), 32'h1);
            check("single_busy", 32'(busy4), 32'h0);
        end
        s_valid4 = 1'b0;
        tick();
        check("single_drain", 32'(m_valid4), 32'h0);

        // Packet lock: select changes after beat 0 are ignored
        beat4(2'd2, 8'h11, 1'b0);
        tick();
        check("lock_b0_valid", 32'(m_valid4), 32'h4);
        check("lock_b0_data", 32'(m_data4), 32'h11);
        check("lock_b0_last", 32'(m_last4), 32'h0);
        check("lock_b0_busy", 32'(busy4), 32'h1);
        beat4(2'd0, 8'h22, 1'b0);
        tick();
        check("lock_b1_valid", 32'(m_valid4), 32'h4);
        check("lock_b1_data", 32'(m_data4), 32'h22);
        check("lock_b1_last", 32'(m_last4), 32'h0);
        check("lock_b1_busy", 32'(busy4), 32'h1);
        beat4(2'd0, 8'h33, 1'b1);
        tick();
        check("lock_b2_valid", 32'(m_valid4), 32'h4);
        check("lock_b2_data", 32'(m_data4), 32'h33);
        check("lock_b2_last", 32'(m_last4), 32'h1);
        check("lock_b2_busy", 32'(busy4), 32'h0);
        s_valid4 = 1'b0;
        tick();

        // Backpressure on ch1 for 3 clocks; other channels' ready ignored
        beat4(2'd1, 8'h44, 1'b0);
        tick();
        check("bp_44", 32'(m_data4), 32'h44);
        beat4(2'd1, 8'h55, 1'b0);
        tick();
        check("bp_55", 32'(m_data4), 32'h55);
        beat4(2'd1, 8'h66, 1'b0);
        m_ready4 = 4'b1101;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_s_ready_low", 32'(s_ready4), 32'h0);
            tick();
            check("bp_hold_data", 32'(m_data4), 32'h55);
            check("bp_hold_valid", 32'(m_valid4), 32'h2);
        end
        m_ready4 = 4'b1111;
        #1;
        check("bp_release_ready", 32'(s_ready4), 32'h1);
        tick();
        check("bp_66", 32'(m_data4), 32'h66);
        check("bp_66_last", 32'(m_last4), 32'h0);
        beat4(2'd3, 8'h77, 1'b1);
        tick();
        check("bp_77", 32'(m_data4), 32'h77);
        check("bp_77_valid", 32'(m_valid4), 32'h2);
        check("bp_77_last", 32'(m_last4), 32'h1);
        s_valid4 = 1'b0;
        tick();
        check("bp_drain", 32'(m_valid4), 32'h0);

        // Mid-packet reset on a packet to ch3
        beat4(2'd3, 8'h81, 1'b0);
        tick();
        check("mid_b0_valid", 32'(m_valid4), 32'h8);
        beat4(2'd3, 8'h82, 1'b0);
        tick();
        check("mid_b1_data", 32'(m_data4), 32'h82);
        check("mid_b1_busy", 32'(busy4), 32'h1);
        s_valid4 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(m_valid4), 32'h0);
        check("mid_rst_busy", 32'(busy4), 32'h0);
        beat4(2'd1, 8'h91, 1'b1);
        tick();
        check("mid_next_valid", 32'(m_valid4), 32'h2);
        check("mid_next_data", 32'(m_data4), 32'h91);
        s_valid4 = 1'b0;
        tick();

        // N_CH=5: highest legal channel still routes
        beat5(3'd4, 8'hC4, 1'b1);
        tick();
        check("ch4_valid", 32'(m_valid5), 32'h10);
        check("ch4_data", 32'(m_data5), 32'hC4);
        s_valid5 = 1'b0;
        tick();

        // Out-of-range 2-beat packet
        beat5(3'd7, 8'hE0, 1'b0);
        #1;
        check("drop_b0_ready", 32'(s_ready5), 32'h1);
        tick();
        check("drop_b0_valid", 32'(m_valid5), 32'h0);
        check("drop_b0_cnt", 32'(drop5), 32'h1);
        check("drop_b0_busy", 32'(busy5), 32'h1);
        beat5(3'd2, 8'hE1, 1'b1);
        #1;
        check("drop_b1_ready", 32'(s_ready5), 32'h1);
        tick();
        check("drop_b1_valid", 32'(m_valid5), 32'h0);
        check("drop_b1_cnt", 32'(drop5), 32'h1);
        check("drop_b1_busy", 32'(busy5), 32'h0);

        // 256 more single-beat dropped packets: count saturates at 255
        for (int i = 0; i < 254; i++) begin
            beat5(3'd6, 8'(i), 1'b1);
            tick();
        end
        check("drop_at_max", 32'(drop5), 32'hFF);
        for (int i = 0; i < 2; i++) begin
            beat5(3'd5, 8'(i), 1'b1);
            tick();
        end
        s_valid5 = 1'b0;
        tick();
        check("drop_saturated", 32'(drop5), 32'hFF);
        check("drop_no_valid", 32'(m_valid5), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1ton

Overview:
Registered 1:N stream demultiplexer with packet-locked channel select. It succeeds the gate-level 1x4 demux, generalised in channel count and data width. It adds valid/ready flow control, one pipeline stage and drop handling for out-of-range selects. The block sits between a single packet source and N independent consumers.

Parameters:
N_CH, 4, number of output channels (2..16)
DATA_W, 8, data width in bits
SEL_W, $clog2(N_CH), select width (derived; do not override)
CNT_W, 8, width of the drop counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
s_valid  input  1  input beat valid
s_ready  output  1  input beat accepted when s_valid && s_ready
s_data  input  DATA_W  input payload
s_sel  input  SEL_W  destination channel; sampled only on the first beat of a packet
s_last  input  1  final beat of packet
m_valid  output  N_CH  one-hot per-channel valid
m_ready  input  N_CH  per-channel ready
m_data  output  DATA_W  payload, shared by all channels
m_last  output  1  final beat, shared by all channels
drop_cnt  output  CNT_W  count of dropped packets, saturating
busy  output  1  high while a packet is open (state != IDLE)

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - m_valid=0, m_data=0, m_last=0, drop_cnt=0, busy=0, state=IDLE, output register empty.
  - s_ready is 0 during reset.
- FSM states IDLE, ROUTE, DROP; a beat is accepted when s_valid && s_ready.
  - IDLE, accepted beat with s_sel < N_CH: lock ch=s_sel and load the beat into the output register. Go to ROUTE, or stay in IDLE if s_last=1 (single-beat packet).
  - IDLE, accepted beat with s_sel >= N_CH: the beat is discarded. Go to DROP, or stay in IDLE if s_last=1. drop_cnt increments on that first beat.
  - ROUTE: every accepted beat goes to the locked ch; s_sel is ignored. An accepted beat with s_last=1 returns the FSM to IDLE.
  - DROP: s_ready=1 unconditionally and beats are discarded. An accepted beat with s_last=1 returns the FSM to IDLE.
- Output register is one entry; ov is its occupancy flag.
  - m_valid = ov ? onehot(out_ch) : 0.
  - Output beat completes when ov && m_ready[out_ch].
  - Outside DROP: s_ready = !ov || m_ready[out_ch]. This path is combinational from m_ready; no combinational path from s_valid to s_ready.
  - A complete and an accept in the same cycle refills the register: throughput 1 beat/clk, ov stays 1.
- Latency: an accepted beat appears on m_* at the next clk edge.
- m_data and m_last hold stable while m_valid!=0 and the selected m_ready=0.
- m_ready bits of non-selected channels are ignored.
- drop_cnt saturates at 2^CNT_W-1; no wrap.
- If N_CH is a power of two, the out-of-range path is unreachable; the logic stays but is constant.
- Reset mid-packet: the buffered beat is lost and the FSM returns to IDLE. The next accepted beat is treated as a packet start with s_sel sampled.
- The first beat of a new packet may be accepted while the previous packet's last beat is still in the output register, even for a different channel. Sequencing is preserved by the single entry.

Decomposition:
- Package demux_pkg holds: the state enum (ST_IDLE, ST_ROUTE, ST_DROP) and the 2-bit state type.
- Sub-module onehot_dec (parameter N; SEL_W in, N out, all-zero output for out-of-range input) generates m_valid. It is the direct generalisation of the existing 1x4 and-gate decode.
- Everything else stays flat in stream_demux_1ton.

Test Plan:
- Reset then idle: hold rst=1 for 2 clk with s_valid=1 -> s_ready=0, m_valid=4'b0000, drop_cnt=0, busy=0.
- Single-beat packets with N_CH=4 and m_ready=4'b1111: send s_sel=0,1,2,3 with data 0xA0..0xA3, s_last=1 each -> m_valid=0001,0010,0100,1000 on consecutive cycles, each 1 clk after its accept, with matching data and m_last=1.
- Packet lock: 3-beat packet with s_sel=2 on beat 0, then s_sel=0 on beats 1-2, data 0x11/0x22/0x33 -> all three beats appear on m_valid=0100; m_last=1 only on 0x33; busy=1 for 2 clk.
- Backpressure: m_ready[1]=0 for 3 clk during a packet to ch1 -> s_ready=0, m_data held at 0x55 for 3 clk. After release, zero beats are lost or duplicated and throughput returns to 1 beat/clk.
- Out-of-range select with N_CH=5 (SEL_W=3): a 2-beat packet with s_sel=7 -> no m_valid bit asserts, s_ready=1, drop_cnt=1. 256 more such packets with CNT_W=8 -> drop_cnt=255 (saturates).
- Reset mid-packet: assert rst after beat 1 of a 4-beat packet to ch3 -> m_valid=0 and state=IDLE next clk. The following beat with s_sel=1 routes to ch1.
